// File: rtl/shiftrows_stream_if.sv
// Byte-lane stream bundle (valid/ready/data/last) shared by the input and output
// sides of the ShiftRows stream stage.
interface shiftrows_stream_if #(
  parameter int unsigned LANES = 1
) ();
  logic               valid;
  logic               ready;
  logic [8*LANES-1:0] data;
  logic               last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/shiftrows_stream.sv
// Streaming AES ShiftRows / InvShiftRows stage: header bytes pass through, each 16-byte body
// block is permuted out of a ping-pong pair of block buffers at one beat per cycle.
module shiftrows_stream #(
  parameter int unsigned LANES     = 1,
  parameter int unsigned HDR_BYTES = 1080,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  shiftrows_stream_if.slave   in_s,
  shiftrows_stream_if.master  out_m,
  input  logic                mode_inv,
  output logic [CNT_W-1:0]    blk_count,
  output logic                err_partial,
  output logic                done
);

  localparam int unsigned HdrBeats = HDR_BYTES / LANES;
  localparam int unsigned HcW      = $clog2(HdrBeats + 2);

  typedef enum logic [1:0] {
    StHdr,
    StBody,
    StFlush
  } state_e;

  localparam state_e StInit = (HdrBeats == 0) ? StBody : StHdr;

  // Source byte for output byte j of a block (k = 4*col + row).
  function automatic logic [3:0] perm_src(input int unsigned j, input logic inv);
    int unsigned c;
    int unsigned r;
    c = (j >> 2) & 32'd3;
    r = j & 32'd3;
    if (inv) begin
      return 4'(4 * ((c + 4 - r) % 4) + r);
    end
    return 4'(4 * ((c + r) % 4) + r);
  endfunction

  state_e           state_q, state_d;
  logic [HcW-1:0]   hdr_cnt_q, hdr_cnt_d;

  logic [8*LANES-1:0] hdr_data_q;
  logic               hdr_valid_q;
  logic               hdr_last_q;

  logic [7:0]       bank_q [2][16];
  logic [1:0]       full_q;
  logic [1:0]       mode_q;
  logic [1:0]       last_q;
  logic [4:0]       len_q [2];
  logic             wr_sel_q;
  logic             rd_sel_q;
  logic [4:0]       fill_q;
  logic [3:0]       rd_beat_q;

  logic [CNT_W-1:0] blk_q;
  logic             err_q;
  logic             done_q;

  logic             in_fire;
  logic             out_fire;
  logic             hdr_push;
  logic             hdr_pop;
  logic             body_push;
  logic             bank_pop;
  logic             rd_is_blk;
  logic             rd_done;
  logic             done_d;
  logic [4:0]       fill_nxt;
  logic [5:0]       rd_bytes_nxt;
  logic [8*LANES-1:0] blk_data;
  int unsigned      idx;

  // Input acceptance depends on the current phase of the frame.
  always_comb begin
    in_s.ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StHdr:   in_s.ready = !hdr_valid_q || out_m.ready;
        StBody:  in_s.ready = !full_q[wr_sel_q];
        default: in_s.ready = 1'b0;
      endcase
    end
  end

  assign in_fire   = in_s.valid && in_s.ready;
  assign hdr_push  = in_fire && (state_q == StHdr);
  assign body_push = in_fire && (state_q == StBody);
  assign fill_nxt  = fill_q + 5'(LANES);

  assign rd_is_blk    = (len_q[rd_sel_q] == 5'd16);
  assign rd_bytes_nxt = ({2'b00, rd_beat_q} + 6'd1) * 6'(LANES);
  assign rd_done      = (rd_bytes_nxt >= {1'b0, len_q[rd_sel_q]});

  // Read-bank beat: full blocks are permuted, a trailing partial block is sent as received.
  always_comb begin
    blk_data = '0;
    idx      = 0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = 32'(rd_beat_q) * LANES + l;
      if (rd_is_blk) begin
        blk_data[8*l +: 8] = bank_q[rd_sel_q][perm_src(idx, mode_q[rd_sel_q])];
      end else begin
        blk_data[8*l +: 8] = bank_q[rd_sel_q][idx[3:0]];
      end
    end
  end

  // A pending header beat always precedes any body output.
  always_comb begin
    out_m.valid = hdr_valid_q || full_q[rd_sel_q];
    out_m.data  = hdr_valid_q ? hdr_data_q : blk_data;
    out_m.last  = hdr_valid_q ? hdr_last_q : (last_q[rd_sel_q] && rd_done);
  end

  assign out_fire = out_m.valid && out_m.ready;
  assign hdr_pop  = out_fire && hdr_valid_q;
  assign bank_pop = out_fire && !hdr_valid_q;
  assign done_d   = out_fire && out_m.last;

  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    unique case (state_q)
      StHdr: begin
        if (in_fire) begin
          hdr_cnt_d = hdr_cnt_q + HcW'(1);
          if (in_s.last) begin
            state_d = StFlush;
          end else if (hdr_cnt_q == HcW'(HdrBeats - 1)) begin
            state_d = StBody;
          end
        end
      end
      StBody: begin
        if (in_fire && in_s.last) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (done_d) begin
          state_d   = StInit;
          hdr_cnt_d = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      hdr_cnt_q   <= '0;
      hdr_data_q  <= '0;
      hdr_valid_q <= 1'b0;
      hdr_last_q  <= 1'b0;
      full_q      <= '0;
      mode_q      <= '0;
      last_q      <= '0;
      len_q[0]    <= '0;
      len_q[1]    <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      fill_q      <= '0;
      rd_beat_q   <= '0;
      blk_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      done_q    <= done_d;

      if (hdr_pop) begin
        hdr_valid_q <= 1'b0;
      end
      if (hdr_push) begin
        hdr_valid_q <= 1'b1;
        hdr_data_q  <= in_s.data;
        hdr_last_q  <= in_s.last;
      end

      if (body_push) begin
        if (fill_q == 5'd0) begin
          mode_q[wr_sel_q] <= mode_inv;
        end
        if ((fill_nxt == 5'd16) || in_s.last) begin
          full_q[wr_sel_q] <= 1'b1;
          len_q[wr_sel_q]  <= fill_nxt;
          last_q[wr_sel_q] <= in_s.last;
          wr_sel_q         <= ~wr_sel_q;
          fill_q           <= '0;
          if (fill_nxt != 5'd16) begin
            err_q <= 1'b1;
          end
        end else begin
          fill_q <= fill_nxt;
        end
      end

      if (bank_pop) begin
        if (rd_done) begin
          full_q[rd_sel_q] <= 1'b0;
          rd_sel_q         <= ~rd_sel_q;
          rd_beat_q        <= '0;
          if (rd_is_blk && (blk_q != '1)) begin
            blk_q <= blk_q + CNT_W'(1);
          end
        end else begin
          rd_beat_q <= rd_beat_q + 4'd1;
        end
      end

      // Count stays visible during the done pulse, then clears for the next frame.
      if (done_q) begin
        blk_q <= '0;
      end
    end
  end

  // Bank storage needs no reset; occupancy is tracked by full_q.
  always_ff @(posedge clk) begin
    if (body_push) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        bank_q[wr_sel_q][4'(32'(fill_q) + l)] <= in_s.data[8*l +: 8];
      end
    end
  end

  assign blk_count   = blk_q;
  assign err_partial = err_q;
  assign done        = done_q;

endmodule

// File: doc/shiftrows_stream.md
Name: shiftrows_stream

Overview:
Synthesizable, streaming successor to the file-driven ShiftRows stage of the AES image pipeline. It accepts a byte stream (BMP header followed by pixel body) on a valid/ready interface. Header bytes pass through unchanged. Each 16-byte body block is permuted with ShiftRows or InvShiftRows, selected per block, using a ping-pong block buffer that sustains full throughput.

Parameters:
LANES, 1, bytes per beat on both interfaces; legal values 1, 2, 4, 8.
HDR_BYTES, 1080, header bytes passed through unmodified at the start of each frame; must be a multiple of LANES.
CNT_W, 16, width of the body block counter.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid and in_ready are both high
in_data  in  8*LANES  lane 0 = [7:0] = earliest byte
in_last  in  1  final beat of the frame
mode_inv  in  1  0 = ShiftRows, 1 = InvShiftRows; sampled on the first beat of each block
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  8*LANES  same lane order as in_data
out_last  out  1  final beat of the frame
blk_count  out  CNT_W  full body blocks emitted this frame
err_partial  out  1  sticky flag: frame ended on a partial block
done  out  1  one-cycle pulse when the out_last beat is accepted

Behaviour:
- Reset (synchronous): out_valid=0, out_last=0, in_ready=0, done=0, err_partial=0, blk_count=0; both banks empty; state=HDR; header counter=0. Reset mid-frame discards all buffered data with no partial output.
- Block indexing: byte k = 4*c + r (column-major, c = column, r = row).
  - ShiftRows: out[4c+r] = in[4*((c+r) mod 4) + r].
  - InvShiftRows: out[4c+r] = in[4*((c-r+4) mod 4) + r].
- States:
  - HDR: single output register. in_ready = !out_valid || out_ready. Each accepted beat appears on out_data the next cycle (latency 1). Exit to BODY after HDR_BYTES/LANES beats.
    - If in_last arrives during HDR: pass the beat with out_last=1, then go to FLUSH.
    - HDR_BYTES=0: start directly in BODY.
  - BODY: two 16-byte banks. Input fills the write bank at byte offset = fill count, LANES bytes per beat.
    - Bank becomes full at fill count 16: mark full, latch mode, toggle the write bank.
    - in_ready = write bank not full.
    - The read bank drains 16/LANES beats of permuted bytes. First out_valid occurs the cycle after the block's last input beat is accepted (latency 1).
    - Filling one bank while draining the other gives one beat per cycle when out_ready is held high.
    - blk_count increments as the last beat of each full block is accepted downstream; it saturates at all-ones.
  - FLUSH: in_ready=0. Drain the remaining banks in order. out_last=1 on the final beat only. done pulses for one cycle on acceptance of that beat. Then return to HDR, with header counter and blk_count cleared on that same cycle.
- in_last on a full-block boundary: that block is emitted with out_last on its final beat.
- in_last mid-block:
  - The partial bank's filled bytes are emitted in arrival order, unpermuted, with out_last on the last of them.
  - err_partial is set and stays set until rst.
  - Only whole beats are valid (fill is a multiple of LANES).
- out_data/out_valid/out_last are held stable while out_valid && !out_ready (no drop, no change).
- Simultaneous events:
  - A bank may be freed (last read beat accepted) and refilled in the same cycle.
  - With both banks full, in_ready=0 until the read bank's last beat is accepted; in_ready rises the following cycle.
- mode_inv changes mid-block are ignored; the value latched on the block's first beat applies to the whole block.

Test Plan:
- LANES=1, HDR_BYTES=4, header AA BB CC DD, then one block 00..0F, mode_inv=0, in_last on byte 0F -> output AA BB CC DD 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; out_last on 0B; done pulses once; blk_count=1.
- Same block with mode_inv=1 -> 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. Feeding the ShiftRows output back with mode_inv=1 returns 00..0F.
- LANES=4, HDR_BYTES=1080, header + 64 blocks, out_ready=1 -> sustained one beat per cycle with no in_ready gaps after the first block; blk_count=64; output header is byte-identical to input.
- Random out_ready (50% duty), LANES=2, 8 blocks with alternating mode_inv -> every stalled beat held stable; per-block permutation matches the latched mode; in_ready=0 whenever both banks are full.
- LANES=1, in_last after byte 5 of a block -> 6 bytes emitted unpermuted with out_last on the sixth; err_partial=1 and stays set.
- rst asserted mid-block with both banks full -> next cycle out_valid=0, blk_count=0, state HDR. The next frame processes correctly from its first header byte.
